reg_wb_arbiter: RTL

//  Write-side partner of the register file: sole driver of its single write port (write_reg/rd/data_in).

---
 rtl/reg_wb_arbiter_pkg.sv | 22 ++
 rtl/reg_wb_arbiter_fifo.sv | 48 ++++
 rtl/reg_wb_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/reg_wb_arbiter_pkg.sv
// Shared types for the register-file write side.
// reg_addr_t : 5-bit architectural register index
// wb_req_t   : one writeback request (destination + data)
// popcount32 : number of set bits in a register mask
package rv_wb_pkg;
  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;

  typedef logic [4:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t       rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  function automatic logic [5:0] popcount32(input logic [NUM_REGS-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < NUM_REGS; i++) n = n + {5'b0, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/reg_wb_arbiter_fifo.sv
// wb_fifo: synchronous FIFO of wb_req_t for long-latency results.
// Ports: clk, reset (sync, active-high), push/din, pop/dout (head, valid
// when !empty), full, empty, count (occupancy).
// Push while full and pop while empty are ignored. On simultaneous
// push+pop the head is read before the new entry is written.
module wb_fifo
  import rv_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  wb_req_t       din,
  input  logic          pop,
  output wb_req_t       dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  wb_req_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: sole driver of the register file write port.
// Merges in-order pipeline writeback with buffered long-latency results
// and tracks outstanding long-latency destinations in pending_mask.
// Ports:
//   clk, reset                       clock, sync active-high reset
//   pipe_wr_en/pipe_rd/pipe_data     pipeline writeback; held off by pipe_stall
//   lr_issue_valid/rd/ready          long-latency issue, marks rd pending
//   lr_resp_valid/rd/data/ready      long-latency result into the FIFO
//   rf_write_reg/rf_rd/rf_data       registered register-file write port
//   pending_mask                     outstanding long-latency destinations
//   fifo_count                       result FIFO occupancy
module reg_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pipe_wr_en,
  input  logic [4:0]                    pipe_rd,
  input  logic [XLEN-1:0]               pipe_data,
  output logic                          pipe_stall,
  input  logic                          lr_issue_valid,
  input  logic [4:0]                    lr_issue_rd,
  output logic                          lr_issue_ready,
  input  logic                          lr_resp_valid,
  input  logic [4:0]                    lr_resp_rd,
  input  logic [XLEN-1:0]               lr_resp_data,
  output logic                          lr_resp_ready,
  output logic                          rf_write_reg,
  output logic [4:0]                    rf_rd,
  output logic [XLEN-1:0]               rf_data,
  output logic [31:0]                   pending_mask,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  import rv_wb_pkg::*;

  localparam int WW = $clog2(STARVE_LIMIT + 1);

  wb_req_t         head, push_req;
  logic            fifo_full, fifo_empty;
  logic            fifo_push, fifo_pop, pipe_sel;
  logic            issue_fire;
  logic            rf_from_fifo;   // current rf_* write came from the FIFO
  logic [WW-1:0]   wait_cnt;
  logic [31:0]     pending_nxt;

  // Arbitration: pipeline first unless the FIFO head has starved.
  assign pipe_stall = (wait_cnt == WW'(STARVE_LIMIT));
  assign pipe_sel   = pipe_wr_en && !pipe_stall;
  assign fifo_pop   = !pipe_sel && !fifo_empty;

  // Results to x0 are acknowledged but never buffered.
  assign lr_resp_ready = !fifo_full;
  assign fifo_push     = lr_resp_valid && lr_resp_ready && (lr_resp_rd != '0);
  assign push_req      = '{rd: lr_resp_rd, data: lr_resp_data};

  // Bounding outstanding issues by FIFO_DEPTH guarantees every result fits.
  // Uses only the registered mask, so a same-edge clear never admits an issue.
  assign lr_issue_ready = !pending_mask[lr_issue_rd] &&
                          (int'(popcount32(pending_mask)) < FIFO_DEPTH);
  assign issue_fire     = lr_issue_valid && lr_issue_ready;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (push_req),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Registered write port; x0 targets drop the strobe but still consume the source.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write_reg <= 1'b0;
      rf_rd        <= '0;
      rf_data      <= '0;
      rf_from_fifo <= 1'b0;
    end else if (pipe_sel) begin
      rf_write_reg <= (pipe_rd != '0);
      rf_rd        <= pipe_rd;
      rf_data      <= pipe_data;
      rf_from_fifo <= 1'b0;
    end else if (fifo_pop) begin
      rf_write_reg <= (head.rd != '0);
      rf_rd        <= head.rd;
      rf_data      <= head.data;
      rf_from_fifo <= 1'b1;
    end else begin
      rf_write_reg <= 1'b0;
      rf_from_fifo <= 1'b0;
    end
  end

  // Counts cycles the FIFO head has been passed over; it can never exceed
  // STARVE_LIMIT because the stall it produces forces a pop.
  always_ff @(posedge clk) begin
    if (reset)                     wait_cnt <= '0;
    else if (fifo_empty || fifo_pop) wait_cnt <= '0;
    else                           wait_cnt <= wait_cnt + 1'b1;
  end

  // Clear lands on the same edge the register file commits the FIFO write.
  always_comb begin
    pending_nxt = pending_mask;
    if (rf_write_reg && rf_from_fifo) pending_nxt[rf_rd] = 1'b0;
    if (issue_fire && (lr_issue_rd != '0)) pending_nxt[lr_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) pending_mask <= '0;
    else       pending_mask <= pending_nxt;
  end
endmodule
